fb_arbiter: RTL

//  Shares the single-port 512x16 framebuffer RAM between the display address generator (read-only,

---
 rtl/fb_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_arbiter
// Brief    : Framebuffer RAM slot arbiter for display fetch, CPU access and
//            full-screen clear. The display always wins the slot.
// Revision : 1.0
// ============================================================================
module fb_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int WORDS  = 512
) (
  input  logic              clk,
  input  logic              res,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CPU_ACC = 2'd1,
    S_CPU_RET = 2'd2,
    S_CLEAR   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_CPU  = 2'd2
  } tag_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_t            state_q, state_d;
  tag_t              tag_q, tag_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              pend_q, pend_d;
  logic              slot_free;

  assign slot_free = ~disp_req;

  always_comb begin
    state_d   = state_q;
    tag_d     = disp_req ? TAG_DISP : TAG_NONE;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = (tag_q == TAG_CPU) ? mem_rdata : rdata_q;
    ack_d     = 1'b0;
    done_d    = 1'b0;
    pend_d    = pend_q;
    mem_addr  = disp_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;

    // A clear request arriving mid CPU op is remembered; during a clear it is dropped.
    if (clr_req && (state_q != S_CLEAR)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_d) begin
          pend_d  = 1'b0;
          state_d = S_CLEAR;
        end else if (cpu_req && !ack_q) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = S_CPU_ACC;
        end
      end
      S_CPU_ACC: begin
        if (slot_free) begin
          mem_addr = addr_q;
          if (we_q) begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
            ack_d     = 1'b1;
            state_d   = S_IDLE;
          end else begin
            tag_d   = TAG_CPU;
            state_d = S_CPU_RET;
          end
        end
      end
      S_CPU_RET: begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (slot_free) begin
          mem_addr = cnt_q;
          mem_we   = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      tag_q   <= TAG_NONE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign disp_valid = (tag_q == TAG_DISP);
  assign disp_data  = mem_rdata;
  assign cpu_ack    = ack_q;
  assign cpu_rdata  = rdata_q;
  assign clr_busy   = (state_q == S_CLEAR);
  assign clr_done   = done_q;

endmodule
`default_nettype wire
